// File: rtl/hier_fanout_node_if.sv
// rtl/hier_fanout_node_if.sv - request/child bundle for one hierarchy fanout node
// master = parent/children environment side, slave = the fanout node itself.
interface hier_fanout_node_if #(
  parameter int NUM_CHILDREN    = 5,
  parameter int DATA_W          = 16,
  parameter int MAX_OUTSTANDING = 4
);
  localparam int CW = $clog2(NUM_CHILDREN);
  localparam int OW = $clog2(NUM_CHILDREN * MAX_OUTSTANDING + 1);

  logic                    req_valid;
  logic                    req_ready;
  logic [DATA_W-1:0]       req_data;
  logic [CW-1:0]           req_dest;
  logic [NUM_CHILDREN-1:0] child_valid;
  logic [NUM_CHILDREN-1:0] child_ready;
  logic [DATA_W-1:0]       child_data;
  logic [NUM_CHILDREN-1:0] child_done;
  logic                    busy;
  logic [OW-1:0]           outstanding_total;
  logic                    err_bad_dest;
  logic                    err_spurious_done;

  modport master (
    output req_valid, req_data, req_dest, child_ready, child_done,
    input  req_ready, child_valid, child_data, busy, outstanding_total,
           err_bad_dest, err_spurious_done
  );

  modport slave (
    input  req_valid, req_data, req_dest, child_ready, child_done,
    output req_ready, child_valid, child_data, busy, outstanding_total,
           err_bad_dest, err_spurious_done
  );
endinterface

// File: rtl/hier_fanout_node.sv
// rtl/hier_fanout_node.sv - stackable request fanout with per-child credits
// One registered stage feeds all children; credits are reserved when a request is accepted.
module hier_fanout_node #(
  parameter int NUM_CHILDREN    = 5,
  parameter int DATA_W          = 16,
  parameter int MAX_OUTSTANDING = 4,
  parameter int ROUTE_MODE      = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  hier_fanout_node_if.slave  port_io
);
  localparam int CW = $clog2(NUM_CHILDREN);
  localparam int OW = $clog2(NUM_CHILDREN * MAX_OUTSTANDING + 1);
  localparam int NW = $clog2(MAX_OUTSTANDING + 1);
  localparam int NP = 1 << CW;
  localparam logic [NW-1:0] CNT_MAX = NW'(MAX_OUTSTANDING);
  localparam logic [CW:0]   NUM_C   = (CW+1)'(NUM_CHILDREN);
  localparam logic [CW-1:0] LAST    = CW'(NUM_CHILDREN - 1);

  // stage_tgt_q is cleared when empty, so it doubles as the one-hot child_valid
  logic [NUM_CHILDREN-1:0] stage_tgt_q, stage_tgt_d;
  logic [DATA_W-1:0]       stage_data_q, stage_data_d;
  logic [NW-1:0]           cnt_q [NUM_CHILDREN];
  logic [NW-1:0]           cnt_d [NUM_CHILDREN];
  logic [CW-1:0]           rr_ptr_q, rr_ptr_d;
  logic [OW-1:0]           total_q, total_d;
  logic                    busy_q, busy_d;
  logic                    err_bad_q, err_bad_d;
  logic                    err_sp_q, err_sp_d;

  logic [NP-1:0]           has_credit;
  logic [NP-1:0]           tgt_oh_full;
  logic [NUM_CHILDREN-1:0] tgt_oh;
  logic [CW-1:0]           tgt_idx;
  logic                    tgt_ok;
  logic                    bad_dest;
  logic                    handoff;
  logic                    stage_free;
  logic                    req_ready;
  logic                    accept;
  logic                    acc_norm;
  logic                    acc_bad;

  // Indices past NUM_CHILDREN read as "no credit" so an out-of-range dest is never a target.
  always_comb begin
    has_credit = '0;
    for (int i = 0; i < NUM_CHILDREN; i++) begin
      has_credit[i] = cnt_q[i] < CNT_MAX;
    end
  end

  always_comb begin : target_sel
    int j;
    j        = 0;
    tgt_idx  = '0;
    tgt_ok   = 1'b0;
    bad_dest = 1'b0;
    if (ROUTE_MODE != 0) begin
      bad_dest = {1'b0, port_io.req_dest} >= NUM_C;
      tgt_idx  = port_io.req_dest;
      tgt_ok   = has_credit[port_io.req_dest];
    end else begin
      // Walk the ring backwards so the last hit is the nearest eligible child from rr_ptr.
      for (int k = NUM_CHILDREN - 1; k >= 0; k--) begin
        j = int'(rr_ptr_q) + k;
        if (j >= NUM_CHILDREN) j = j - NUM_CHILDREN;
        if (has_credit[CW'(j)]) begin
          tgt_idx = CW'(j);
          tgt_ok  = 1'b1;
        end
      end
    end
  end

  assign tgt_oh_full = NP'(1) << tgt_idx;
  assign tgt_oh      = tgt_oh_full[NUM_CHILDREN-1:0];

  assign handoff    = |(stage_tgt_q & port_io.child_ready);
  assign stage_free = ~|stage_tgt_q || handoff;
  assign req_ready  = bad_dest ? stage_free : (stage_free && tgt_ok);
  assign accept     = port_io.req_valid && req_ready;
  assign acc_norm   = accept && !bad_dest;
  assign acc_bad    = accept && bad_dest;

  always_comb begin
    stage_tgt_d  = stage_tgt_q;
    stage_data_d = stage_data_q;
    rr_ptr_d     = rr_ptr_q;
    if (acc_norm) begin
      stage_tgt_d  = tgt_oh;
      stage_data_d = port_io.req_data;
      if (ROUTE_MODE == 0) begin
        rr_ptr_d = (tgt_idx == LAST) ? '0 : tgt_idx + 1'b1;
      end
    end else if (handoff) begin
      stage_tgt_d = '0;
    end
  end

  // A done on an empty counter is reported but never wraps the counter.
  always_comb begin
    logic inc;
    logic dec;
    inc      = 1'b0;
    dec      = 1'b0;
    err_sp_d = 1'b0;
    total_d  = '0;
    for (int i = 0; i < NUM_CHILDREN; i++) begin
      cnt_d[i] = cnt_q[i];
      inc      = acc_norm && tgt_oh[i];
      dec      = port_io.child_done[i] && (cnt_q[i] != '0);
      if (port_io.child_done[i] && (cnt_q[i] == '0)) err_sp_d = 1'b1;
      if (inc && !dec)      cnt_d[i] = cnt_q[i] + 1'b1;
      else if (dec && !inc) cnt_d[i] = cnt_q[i] - 1'b1;
      total_d = total_d + OW'(cnt_d[i]);
    end
    busy_d    = (|stage_tgt_d) || (total_d != '0);
    err_bad_d = acc_bad;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_tgt_q  <= '0;
      stage_data_q <= '0;
      rr_ptr_q     <= '0;
      total_q      <= '0;
      busy_q       <= 1'b0;
      err_bad_q    <= 1'b0;
      err_sp_q     <= 1'b0;
      for (int i = 0; i < NUM_CHILDREN; i++) cnt_q[i] <= '0;
    end else begin
      stage_tgt_q  <= stage_tgt_d;
      stage_data_q <= stage_data_d;
      rr_ptr_q     <= rr_ptr_d;
      total_q      <= total_d;
      busy_q       <= busy_d;
      err_bad_q    <= err_bad_d;
      err_sp_q     <= err_sp_d;
      for (int i = 0; i < NUM_CHILDREN; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign port_io.req_ready         = req_ready;
  assign port_io.child_valid       = stage_tgt_q;
  assign port_io.child_data        = stage_data_q;
  assign port_io.busy              = busy_q;
  assign port_io.outstanding_total = total_q;
  assign port_io.err_bad_dest      = err_bad_q;
  assign port_io.err_spurious_done = err_sp_q;
endmodule

// File: doc/hier_fanout_node.md
# hier_fanout_node

Parametrised hierarchy node that takes one request stream and distributes it across `NUM_CHILDREN` child instances. It replaces the fixed five-child, portless hierarchy nodes in the design.
- Routing is either round-robin or addressed.
- Per-child credit counters bound the number of outstanding requests per child.
- A single registered output stage drives the children.
- It sits between a parent node (or the top-level stimulus source) and its children, so the same block can be stacked at every hierarchy level.

## Interface
Parameters:
- NUM_CHILDREN, default 5: number of child ports; legal range 2..16.
- DATA_W, default 16: payload width.
- MAX_OUTSTANDING, default 4: credit limit per child; legal range 1..15.
- ROUTE_MODE, default 0: 0 = round-robin, 1 = addressed by req_dest.

Derived widths:
- CW = $clog2(NUM_CHILDREN)
- OW = $clog2(NUM_CHILDREN*MAX_OUTSTANDING+1)

Ports (clock and reset first):
- clk, in, 1: single clock; all state updates on rising edge.
- rst_n, in, 1: reset, asynchronous and active-low.
- req_valid, in, 1: request present.
- req_ready, out, 1: request accepted when req_valid && req_ready.
- req_data, in, DATA_W: request payload.
- req_dest, in, CW: target child index; ignored when ROUTE_MODE = 0.
- child_valid, out, NUM_CHILDREN: one-hot; bit i means the payload is offered to child i.
- child_ready, in, NUM_CHILDREN: child i accepts when child_valid[i] && child_ready[i].
- child_data, out, DATA_W: shared payload bus to all children.
- child_done, in, NUM_CHILDREN: single-cycle completion pulse per child; multiple bits may be set at once.
- busy, out, 1: output stage occupied, or any credit counter nonzero.
- outstanding_total, out, OW: sum of all credit counters.
- err_bad_dest, out, 1: one-cycle pulse, addressed request with req_dest >= NUM_CHILDREN.
- err_spurious_done, out, 1: one-cycle pulse, child_done seen on a child whose counter is 0.

## Operation
State held in the block:
- Output stage: stage_valid, stage_tgt (one-hot), stage_data.
- Credit counters: cnt[i], 0..MAX_OUTSTANDING, one per child.
- Round-robin pointer: rr_ptr, CW bits.

Target selection:
- Addressed mode: target = req_dest.
- Round-robin mode: target = first child j, searching cyclically from rr_ptr, with cnt[j] < MAX_OUTSTANDING.
- Round-robin mode with no such child: no target, so req_ready = 0.

Request acceptance:
- stage_free = !stage_valid || (child_ready & stage_tgt) != 0.
- req_ready = stage_free && a target exists && cnt[target] < MAX_OUTSTANDING.
- Exception: an addressed bad-dest request has req_ready = stage_free.

On an accepted normal request:
- stage_valid becomes 1, stage_tgt = target, stage_data = req_data.
- cnt[target] increments; the credit is reserved at acceptance, not at handoff.
- In round-robin mode only, rr_ptr becomes (target+1) mod NUM_CHILDREN.

On an accepted bad-dest request:
- The request is consumed and dropped.
- err_bad_dest pulses.
- No counter changes, and stage_valid is cleared if it was handed off this cycle.

Handoff and completion:
- Handoff: when child_ready[tgt] is high and stage_valid is set, stage_valid clears unless a new request loads in the same cycle.
- child_done[i] with cnt[i] > 0: cnt[i] decrements.
- child_done[i] with cnt[i] == 0: the pulse is ignored, err_spurious_done pulses, and cnt[i] stays 0.
- Same child incremented and done in the same cycle: cnt is unchanged.

Outputs:
- outstanding_total and busy are registered and reflect post-update counter state.

## Timing
- Reset values (async assert, sync-safe deassert): stage_valid = 0, child_valid = 0, child_data = 0, all cnt = 0, rr_ptr = 0, busy = 0, outstanding_total = 0, both err outputs = 0.
- Latency: a request accepted at edge N gives child_valid high from cycle N+1.
- Throughput: one request per cycle when children are always ready.
- Handshake: child_valid and child_data stay stable until the child handshakes; child_valid never drops without a handshake.
- req_ready: combinational from child_ready and the counters; the upstream side must not wait on req_ready before asserting req_valid.
- Reset mid-operation: the pending stage and all credits are discarded; child_done pulses arriving after reset count as spurious.

## Test plan
- Round-robin, defaults, 5 requests (data 0x10..0x14), children always ready:
  - child_valid sequence 00001, 00010, 00100, 01000, 10000, one per cycle.
  - outstanding_total reaches 5.
- Credit limit, MAX_OUTSTANDING = 4, addressed to child 2, no child_done:
  - 4 requests accepted, then req_ready = 0.
  - One child_done[2] pulse restores exactly one acceptance.
- Backpressure, child_ready[1] low for 3 cycles:
  - child_valid = 00010 and child_data = 0x55 hold stable for those 3 cycles.
  - req_ready = 0 during the stall; the handoff occurs in cycle 4.
- Round-robin skip with cnt[0] = 4 and rr_ptr = 0: the next request routes to child 1 and rr_ptr becomes 2.
- Errors:
  - Addressed req_dest = 6 with NUM_CHILDREN = 5: err_bad_dest pulses for one cycle, no child_valid, counters unchanged.
  - child_done[3] with cnt[3] = 0: err_spurious_done pulses for one cycle.
- Reset mid-operation: assert rst_n = 0 with 3 outstanding and a stage pending; all outputs return to 0 immediately, and busy = 0 after release.
